pll_clken_nco: RTL and testbench
================================

Name: pll_clken_nco

Overview:
- Multi-channel NCO clock-enable generator that sits downstream of the CPU PLL.
- Qualifies the PLL LOCK signal with a stability counter.
- Once lock is stable, produces per-channel single-cycle clock enables and square-wave phase outputs (e.g. UART x16 baud, timer ticks) at runtime-programmable fractional rates.
- Increments can be retuned without glitches: a new value takes effect only at the channel's accumulator wrap.

Parameters:
- CHANNELS, 2, number of independent NCO channels (1..8).
- ACC_W, 24, accumulator and increment width in bits. f_en = f_CLK * INC / 2^ACC_W.
- LOCK_STABLE_CYCLES, 1024, consecutive LOCK-high cycles required before READY asserts (>=2).
- INC_RESET, 0, increment loaded into every channel at reset.

Ports:
- CLK  in  1  system clock (PLLOUTGLOBAL domain).
- RESET  in  1  synchronous, active-low reset.
- PLL_LOCK  in  1  raw PLL LOCK. Already synchronous to CLK.
- INC_WR  in  1  write strobe for the increment.
- CH_SEL  in  $clog2(CHANNELS) (min 1)  target channel for INC_WR.
- INC_DATA  in  ACC_W  new increment value.
- READY  out  1  lock is stable; NCOs are running.
- CLK_EN  out  CHANNELS  one-cycle enable pulse per accumulator wrap.
- PHASE_MSB  out  CHANNELS  acc[i][ACC_W-1], an approximately 50% square wave.
- INC_PENDING  out  CHANNELS  a written increment is awaiting its apply point.
- LOCK_LOST  out  1  sticky lock-loss flag (optional feature).
- LOCK_LOST_CLR  in  1  clears LOCK_LOST (optional feature).

Behaviour:
- Reset (RESET=0 sampled at a CLK edge):
  - READY=0; lock counter=0; all acc=0; CLK_EN=0; PHASE_MSB=0; INC_PENDING=0; LOCK_LOST=0.
  - Active increment = INC_RESET for every channel.
  - Reset asserted mid-operation aborts everything at that edge, including pending writes.
- Lock qualifier:
  - Counter increments while PLL_LOCK=1 and saturates at LOCK_STABLE_CYCLES-1.
  - Counter clears on any cycle with PLL_LOCK=0.
  - READY is registered: it goes 1 at the edge where the counter reaches LOCK_STABLE_CYCLES-1, and goes 0 at the first edge that samples PLL_LOCK=0.
- NCO, per channel, on each edge while READY=1:
  - {carry, acc} <= acc + inc_active (ACC_W+1-bit sum; modulo 2^ACC_W wrap).
  - CLK_EN[i] <= carry, registered in the same edge.
  - Example: with inc=2^(ACC_W-2), the first pulse is high after the 4th update edge following READY rising, then repeats every 4 cycles.
  - inc=0 means the channel is stopped: no pulses, acc frozen.
- While READY=0: acc held at 0, CLK_EN=0, PHASE_MSB=0.
- Increment update:
  - INC_WR with CH_SEL < CHANNELS stores INC_DATA into the channel's pending register and sets INC_PENDING[i].
  - INC_WR with CH_SEL >= CHANNELS is ignored.
  - A second write while a value is pending overwrites it; last write wins.
- Apply point for a pending increment: the first edge where any of the following holds. At that edge inc_active <= pending and INC_PENDING[i] clears.
  - (a) that channel's carry=1; the sum at that edge still uses the old increment.
  - (b) inc_active=0.
  - (c) READY=0.
- INC_WR on the same edge as an apply point: the new INC_DATA is applied directly, bypassing the old pending value, and INC_PENDING stays 0.
- Channels are fully independent; simultaneous carries on all channels are legal.

Optional Feature:
- PLL_LOCK_LOSS_STICKY_EN defined:
  - LOCK_LOST sets at the edge where READY falls because PLL_LOCK=0.
  - LOCK_LOST clears only on reset or on LOCK_LOST_CLR=1.
  - If set and clear happen on the same edge, set wins.
- PLL_LOCK_LOSS_STICKY_EN undefined: LOCK_LOST is tied 0 and LOCK_LOST_CLR is ignored.

Test Plan:
All scenarios use ACC_W=8, CHANNELS=2, LOCK_STABLE_CYCLES=16.
1. RESET low 3 cycles, then PLL_LOCK=1 continuously -> READY rises at the 16th LOCK-high edge. Pull LOCK low for 1 cycle at cycle 10 -> READY is delayed a further 16 cycles.
2. ch0 inc=64, ch1 inc=128 after READY -> CLK_EN[0] every 4 cycles, first pulse at the 4th update edge; CLK_EN[1] every 2 cycles. PHASE_MSB[0] is 2 high / 2 low.
3. ch0 inc=3 -> exactly 3 pulses per 256 cycles over 1024 cycles (12 total); no two pulses adjacent.
4. ch0 running inc=64, write inc=128 mid-period -> INC_PENDING[0]=1 until the next CLK_EN[0] edge. Old 4-cycle spacing holds through that pulse, 2-cycle spacing follows; two back-to-back writes leave only the last value applied.
5. Drop PLL_LOCK while running -> next edge READY=0, CLK_EN=0, acc=0. With the macro defined, LOCK_LOST=1 until LOCK_LOST_CLR; with set and clear on the same edge, LOCK_LOST stays 1.
6. INC_WR with CH_SEL=3 (out of range), and write inc=0 -> no state change for the out-of-range write; inc=0 stops pulses immediately and a later nonzero write applies on the next edge.

Source files
------------

// File: rtl/pll_clken_nco.sv
// pll_clken_nco: lock-qualified multi-channel NCO clock-enable generator.
// Optional sticky lock-loss flag: define PLL_LOCK_LOSS_STICKY_EN.
module pll_clken_nco #(
  parameter int CHANNELS = 2,
  parameter int ACC_W = 24,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_RESET = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic inc_wr,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  input  logic [ACC_W-1:0] inc_data,
  output logic ready,
  output logic [CHANNELS-1:0] clk_en,
  output logic [CHANNELS-1:0] phase_msb,
  output logic [CHANNELS-1:0] inc_pending,
  output logic lock_lost,
  input  logic lock_lost_clr
);

  localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic run;

  // ready needs CNT_MAX prior lock-high cycles plus the current one
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else if (!pll_lock) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      ready <= (cnt == CNT_MAX);
    end
  end

  assign run = ready & pll_lock;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] inc_pend;
    logic [ACC_W:0] sum;
    logic en_q;
    logic pend_q;
    logic carry;
    logic apply;
    logic hit;

    assign sum   = {1'b0, acc} + {1'b0, inc_act};
    assign carry = run & sum[ACC_W];
    assign apply = carry | ~|inc_act | ~ready;
    assign hit   = inc_wr & (int'(ch_sel) == i);

    always_ff @(posedge clk) begin
      if (!reset) begin
        acc      <= '0;
        en_q     <= 1'b0;
        inc_act  <= INC_RESET;
        inc_pend <= '0;
        pend_q   <= 1'b0;
      end else begin
        acc  <= run ? sum[ACC_W-1:0] : '0;
        en_q <= carry;
        if (apply && hit) begin
          inc_act <= inc_data;
          pend_q  <= 1'b0;
        end else if (apply && pend_q) begin
          inc_act <= inc_pend;
          pend_q  <= 1'b0;
        end else if (hit) begin
          inc_pend <= inc_data;
          pend_q   <= 1'b1;
        end
      end
    end

    assign clk_en[i]      = en_q;
    assign phase_msb[i]   = acc[ACC_W-1];
    assign inc_pending[i] = pend_q;
  end

`ifdef PLL_LOCK_LOSS_STICKY_EN
  logic lost_q;

  // a loss on the same edge as a clear still latches
  always_ff @(posedge clk) begin
    if (!reset) begin
      lost_q <= 1'b0;
    end else if (ready && !pll_lock) begin
      lost_q <= 1'b1;
    end else if (lock_lost_clr) begin
      lost_q <= 1'b0;
    end
  end

  assign lock_lost = lost_q;
`else
  logic unused_clr;

  assign unused_clr = lock_lost_clr;
  assign lock_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_pll_clken_nco.sv
// tb_pll_clken_nco: vector table, directed corner sequences and random
// stimulus checked against a cycle-level arithmetic reference model.
`timescale 1ns/1ps
module tb_pll_clken_nco;

  localparam int AW  = 8;
  localparam int NCH = 2;
  localparam int LSC = 16;
  localparam int MOD = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pll_lock = 1'b0;
  logic inc_wr = 1'b0;
  logic lock_lost_clr = 1'b0;
  logic [0:0] ch_sel = '0;
  logic [AW-1:0] inc_data = '0;
  logic ready;
  logic lock_lost;
  logic [NCH-1:0] clk_en;
  logic [NCH-1:0] phase_msb;
  logic [NCH-1:0] inc_pending;

  logic lock3 = 1'b0;
  logic wr3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic [AW-1:0] data3 = '0;
  logic ready3;
  logic lost3;
  logic [2:0] en3;
  logic [2:0] ph3;
  logic [2:0] pend3;

  always #5 clk = ~clk;

  pll_clken_nco #(
    .CHANNELS(NCH), .ACC_W(AW), .LOCK_STABLE_CYCLES(LSC),
    .INC_RESET('0)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock),
    .inc_wr(inc_wr), .ch_sel(ch_sel), .inc_data(inc_data),
    .ready(ready), .clk_en(clk_en), .phase_msb(phase_msb),
    .inc_pending(inc_pending), .lock_lost(lock_lost),
    .lock_lost_clr(lock_lost_clr)
  );

  pll_clken_nco #(
    .CHANNELS(3), .ACC_W(AW), .LOCK_STABLE_CYCLES(LSC),
    .INC_RESET('0)
  ) dut3 (
    .clk(clk), .reset(reset), .pll_lock(lock3),
    .inc_wr(wr3), .ch_sel(sel3), .inc_data(data3),
    .ready(ready3), .clk_en(en3), .phase_msb(ph3),
    .inc_pending(pend3), .lock_lost(lost3),
    .lock_lost_clr(1'b0)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: consecutive-lock streak and integer accumulators
  int streak;
  bit m_ready;
  bit m_lost;
  int m_acc [NCH];
  int m_inc [NCH];
  int m_pv [NCH];
  bit m_pf [NCH];
  bit m_en [NCH];

  function automatic void model_edge();
    bit run;
    bit carry;
    bit app;
    bit hit;
    int s;
    if (!reset) begin
      streak = 0;
      m_ready = 0;
      m_lost = 0;
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0; m_inc[i] = 0; m_pv[i] = 0;
        m_pf[i] = 0; m_en[i] = 0;
      end
      return;
    end
    run = m_ready && pll_lock;
    for (int i = 0; i < NCH; i++) begin
      s = m_acc[i] + m_inc[i];
      carry = run && (s >= MOD);
      m_acc[i] = run ? (s % MOD) : 0;
      m_en[i] = carry;
      app = carry || (m_inc[i] == 0) || !m_ready;
      hit = inc_wr && (int'(ch_sel) == i);
      if (app && hit) begin
        m_inc[i] = int'(inc_data); m_pf[i] = 0;
      end else if (app && m_pf[i]) begin
        m_inc[i] = m_pv[i]; m_pf[i] = 0;
      end else if (hit) begin
        m_pv[i] = int'(inc_data); m_pf[i] = 1;
      end
    end
`ifdef PLL_LOCK_LOSS_STICKY_EN
    if (m_ready && !pll_lock) m_lost = 1;
    else if (lock_lost_clr) m_lost = 0;
`else
    m_lost = 0;
`endif
    streak = pll_lock ? streak + 1 : 0;
    m_ready = (streak >= LSC);
  endfunction

  task automatic check_model();
    int e = 0;
    int p = 0;
    int q = 0;
    for (int i = 0; i < NCH; i++) begin
      e |= int'(m_en[i]) << i;
      p |= int'(m_acc[i] >= MOD / 2) << i;
      q |= int'(m_pf[i]) << i;
    end
    chk("m_ready", int'(ready), int'(m_ready));
    chk("m_clk_en", int'(clk_en), e);
    chk("m_phase", int'(phase_msb), p);
    chk("m_pending", int'(inc_pending), q);
    chk("m_lock_lost", int'(lock_lost), int'(m_lost));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wait_pulse(input int ch, output int k);
    k = 0;
    while (1) begin
      step();
      k++;
      if (clk_en[ch]) break;
      if (k >= 600) begin
        chk("pulse_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_nopend(input int ch);
    int k = 0;
    while (inc_pending[ch]) begin
      step();
      k++;
      if (k >= 600) begin
        chk("pending_timeout", 0, 1);
        break;
      end
    end
  endtask

  typedef struct {
    bit rst; bit lock; bit wr; int sel; int data;
    int rdy; int en; int ph; int pend;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit lock, bit wr, int sel,
                              int data, int rdy, int en, int ph,
                              int pend);
    vec_t v;
    v.rst = rst; v.lock = lock; v.wr = wr; v.sel = sel;
    v.data = data; v.rdy = rdy; v.en = en; v.ph = ph; v.pend = pend;
    tbl.push_back(v);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    int adj;
    int e_rdy;
    bit prev;

    // reset, write increments during lock qualification, first pulses
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 64, 0, 0, 0, 0);
    add(1, 1, 1, 1, 128, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 2, 0);
    add(1, 1, 0, 0, 0, 1, 2, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0, 3, 0);
    add(1, 1, 0, 0, 0, 1, 3, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 2, 0);
    add(1, 1, 0, 0, 0, 1, 2, 1, 0);

    foreach (tbl[r]) begin
      reset = tbl[r].rst;
      pll_lock = tbl[r].lock;
      inc_wr = tbl[r].wr;
      ch_sel = 1'(tbl[r].sel);
      inc_data = AW'(tbl[r].data);
      step();
      chk("tbl_ready", int'(ready), tbl[r].rdy);
      chk("tbl_clk_en", int'(clk_en), tbl[r].en);
      chk("tbl_phase", int'(phase_msb), tbl[r].ph);
      chk("tbl_pending", int'(inc_pending), tbl[r].pend);
      chk("tbl_lock_lost", int'(lock_lost), 0);
    end
    inc_wr = 0;

    // retune mid-period: old spacing through the wrap, then new
    inc_wr = 1; ch_sel = 0; inc_data = 128;
    step();
    inc_wr = 0;
    chk("retune_pending", int'(inc_pending[0]), 1);
    wait_pulse(0, k);
    chk("retune_old_pulse", k, 1);
    chk("retune_pend_clr", int'(inc_pending[0]), 0);
    wait_pulse(0, k);
    chk("retune_new_spacing", k, 2);

    // two back-to-back writes: only the last one lands
    inc_wr = 1; inc_data = 16;
    step();
    inc_wr = 0;
    wait_nopend(0);
    wait_pulse(0, k);
    chk("inc16_spacing", k, 16);
    inc_wr = 1; inc_data = 64;
    step();
    inc_data = 32;
    step();
    inc_wr = 0;
    chk("b2b_pending", int'(inc_pending[0]), 1);
    wait_pulse(0, k);
    wait_pulse(0, k);
    chk("last_write_wins", k, 8);

    // fractional rate: 3/256 over 1024 cycles
    inc_wr = 1; inc_data = 3;
    step();
    inc_wr = 0;
    wait_nopend(0);
    cnt = 0; adj = 0; prev = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (clk_en[0]) cnt++;
      if (clk_en[0] && prev) adj++;
      prev = clk_en[0];
    end
    chk("inc3_pulses", cnt, 12);
    chk("inc3_adjacent", adj, 0);

    // out-of-range channel select on a 3-channel instance
    wr3 = 1; sel3 = 3; data3 = 128;
    step();
    wr3 = 0; lock3 = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (en3 != 0 || pend3 != 0) cnt++;
    end
    chk("oor_no_effect", cnt, 0);
    chk("oor_ready3", int'(ready3), 1);
    wr3 = 1; sel3 = 2; data3 = 64;
    step();
    wr3 = 0;
    chk("ch2_direct_pend", int'(pend3), 0);
    cnt = 0; adj = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (en3[2]) cnt++;
      if (en3[1:0] != 0) adj++;
    end
    chk("ch2_pulses", cnt, 4);
    chk("ch2_others_idle", adj, 0);

    // inc=0 stops the channel; a later write applies straight away
    inc_wr = 1; ch_sel = 1; inc_data = 0;
    step();
    inc_wr = 0;
    wait_nopend(1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (clk_en[1]) cnt++;
    end
    chk("stopped_pulses", cnt, 0);
    inc_wr = 1; inc_data = 128;
    step();
    inc_wr = 0;
    chk("restart_pend", int'(inc_pending[1]), 0);
    step();
    step();
    chk("restart_pulse", int'(clk_en[1]), 1);

    // lock loss while running
    pll_lock = 0;
    step();
    chk("loss_ready", int'(ready), 0);
    chk("loss_clk_en", int'(clk_en), 0);
    chk("loss_phase", int'(phase_msb), 0);
`ifdef PLL_LOCK_LOSS_STICKY_EN
    chk("loss_flag", int'(lock_lost), 1);
`else
    chk("loss_flag", int'(lock_lost), 0);
`endif
    pll_lock = 1;
    k = 0;
    while (!ready && k < 40) begin
      step();
      k++;
    end
    chk("relock_latency", k, 16);
    pll_lock = 0; lock_lost_clr = 1;
    step();
`ifdef PLL_LOCK_LOSS_STICKY_EN
    chk("set_beats_clr", int'(lock_lost), 1);
`else
    chk("set_beats_clr", int'(lock_lost), 0);
`endif
    step();
    chk("flag_cleared", int'(lock_lost), 0);
    lock_lost_clr = 0;

    // reset mid-operation drops a pending write
    pll_lock = 1;
    k = 0;
    while (!ready && k < 40) begin
      step();
      k++;
    end
    inc_wr = 1; ch_sel = 0; inc_data = 77;
    step();
    inc_wr = 0; reset = 0;
    step();
    chk("rst_pending", int'(inc_pending), 0);
    chk("rst_ready", int'(ready), 0);
    step();
    step();

    // one-cycle lock glitch at the 10th edge restarts qualification
    reset = 1;
    e_rdy = 0;
    for (int e = 1; e <= 40; e++) begin
      pll_lock = (e != 10);
      step();
      if (ready) begin
        e_rdy = e;
        break;
      end
    end
    chk("glitch_ready_edge", e_rdy, 26);
    pll_lock = 1;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 999) != 0);
      pll_lock = ($urandom_range(0, 149) != 0);
      inc_wr = ($urandom_range(0, 7) == 0);
      ch_sel = 1'($urandom_range(0, 1));
      inc_data = ($urandom_range(0, 5) == 0) ? '0
               : AW'($urandom_range(1, 255));
      lock_lost_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
